// File: rtl/reg_stream_pkg.sv
// Shared types and constants for the register-block streamer.
package reg_stream_pkg;

    localparam int NB_MAX = 64;
    localparam int DW     = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic       is_idx;
        logic [5:0] idx;
        logic       last;
    } slot_t;

endpackage

// File: rtl/reg_stream_fifo.sv
// Synchronous FIFO for the streamer output: data + last, with occupancy count.
module reg_stream_fifo #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          wr_last_i,
    input  logic          rd_en_i,
    output logic          rd_valid_o,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_last_o,
    output logic [CW-1:0] count_o
);

    logic [DW:0]   mem_q [DEPTH];
    logic [PW-1:0] wp_q;
    logic [PW-1:0] rp_q;
    logic [CW-1:0] cnt_q;
    logic          pop;

    assign pop = rd_en_i && (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en_i) wp_q <= wp_q + PW'(1);
            if (pop)     rp_q <= rp_q + PW'(1);
            cnt_q <= cnt_q + CW'(wr_en_i) - CW'(pop);
        end
    end

    // Storage needs no reset; the count gates what is visible.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wp_q] <= {wr_last_i, wr_data_i};
    end

    assign rd_valid_o             = (cnt_q != '0);
    assign {rd_last_o, rd_data_o} = rd_valid_o ? mem_q[rp_q] : '0;
    assign count_o                = cnt_q;

endmodule

// File: rtl/reg_block_streamer.sv
// Reads N register blocks from table BRAM and emits them as one AXI-Stream frame.
module reg_block_streamer
    import reg_stream_pkg::*;
#(
    parameter int NREG       = 10,
    parameter int MEM_LAT    = 2,
    parameter int AW         = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [5:0]    first_blk,
    input  logic [6:0]    nblk,
    output logic          busy,
    output logic          done,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tlast
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int JW = $clog2(NREG + 1);

    state_t        state_q, state_d;
    logic [5:0]    blk_q, blk_d;
    logic [6:0]    left_q, left_d;
    logic [JW-1:0] j_q, j_d;

    logic [MEM_LAT-1:0] pv_q;
    slot_t              pt_q [MEM_LAT];

    logic [CW-1:0] fcnt;
    logic [CW-1:0] infl;
    logic [CW:0]   occ;
    logic          credit;
    logic          issue;
    slot_t         slot;
    logic          hs_last;
    slot_t         tail;
    logic [DW-1:0] wr_data;

    always_comb begin
        infl = '0;
        for (int i = 0; i < MEM_LAT; i++) infl = infl + CW'(pv_q[i]);
    end

    // Credits cover both the FIFO contents and every read still in flight.
    assign occ     = {1'b0, infl} + {1'b0, fcnt};
    assign credit  = occ < (CW+1)'(FIFO_DEPTH);
    assign hs_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        left_d   = left_q;
        j_d      = j_q;
        issue    = 1'b0;
        mem_en   = 1'b0;
        mem_addr = '0;
        slot     = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    blk_d   = first_blk;
                    left_d  = nblk;
                    j_d     = '0;
                    state_d = (nblk == 7'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue       = 1'b1;
                    slot.is_idx = (j_q == '0);
                    slot.idx    = blk_q;
                    slot.last   = (left_q == 7'd1) && (j_q == JW'(NREG));
                    if (j_q != '0) begin
                        mem_en   = 1'b1;
                        mem_addr = AW'(blk_q) * AW'(NREG) + AW'(j_q - JW'(1));
                    end
                    if (j_q == JW'(NREG)) begin
                        j_d    = '0;
                        blk_d  = blk_q + 6'd1;
                        left_d = left_q - 7'd1;
                        if (left_q == 7'd1) state_d = DRAIN;
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end
            end
            DRAIN: begin
                if (hs_last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            left_q  <= '0;
            j_q     <= '0;
            pv_q    <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            left_q  <= left_d;
            j_q     <= j_d;
            pv_q[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) pv_q[i] <= pv_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pt_q[0] <= slot;
        for (int i = 1; i < MEM_LAT; i++) pt_q[i] <= pt_q[i-1];
    end

    assign tail    = pt_q[MEM_LAT-1];
    assign wr_data = tail.is_idx ? {26'b0, tail.idx} : mem_dout;

    reg_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (pv_q[MEM_LAT-1]),
        .wr_data_i  (wr_data),
        .wr_last_i  (tail.last),
        .rd_en_i    (m_axis_tready),
        .rd_valid_o (m_axis_tvalid),
        .rd_data_o  (m_axis_tdata),
        .rd_last_o  (m_axis_tlast),
        .count_o    (fcnt)
    );

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_reg_block_streamer.sv
// Directed bench for reg_block_streamer with a 2-cycle BRAM model holding mem[a]=a.
module tb_reg_block_streamer;

    localparam int NREG       = 10;
    localparam int MEM_LAT    = 2;
    localparam int AW         = 10;
    localparam int FIFO_DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [5:0]    first_blk;
    logic [6:0]    nblk;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_dout;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tlast;

    reg_block_streamer #(
        .NREG       (NREG),
        .MEM_LAT    (MEM_LAT),
        .AW         (AW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .first_blk     (first_blk),
        .nblk          (nblk),
        .busy          (busy),
        .done          (done),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_dout      (mem_dout),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    logic [AW-1:0] a1, a2;
    always @(posedge clk) begin
        a1 <= mem_addr;
        a2 <= a1;
    end
    assign mem_dout = {22'b0, a2};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q_data[$];
    logic        q_last[$];
    logic [31:0] q_addr[$];
    logic [31:0] e_data[$];
    logic [31:0] e_addr[$];
    int n_en, n_done, n_busy, n_tv, n_stab;
    int first_tv, first_hs, last_cyc, done_cyc, st_cyc;
    logic        stall_p = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
            if (q_data.size() == 1) first_hs = cyc;
            if (m_axis_tlast) last_cyc = cyc;
        end
        if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
        if (m_axis_tvalid) n_tv++;
        if (mem_en) begin
            q_addr.push_back(32'(mem_addr));
            n_en++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (busy) n_busy++;
        if (stall_p && (!m_axis_tvalid || m_axis_tdata !== hold_d
                        || m_axis_tlast !== hold_l))
            n_stab++;
        stall_p = m_axis_tvalid && !m_axis_tready && !rst;
        hold_d  = m_axis_tdata;
        hold_l  = m_axis_tlast;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        q_data.delete();
        q_last.delete();
        q_addr.delete();
        n_en = 0; n_done = 0; n_busy = 0; n_tv = 0; n_stab = 0;
        first_tv = -1; first_hs = -1; last_cyc = -1; done_cyc = -1;
    endtask

    task automatic build(int f, int n);
        e_data.delete();
        e_addr.delete();
        for (int k = 0; k < n; k++) begin
            int b;
            b = (f + k) % 64;
            e_data.push_back(32'(b));
            for (int j = 0; j < NREG; j++) begin
                e_addr.push_back(32'(b * NREG + j));
                e_data.push_back(32'(b * NREG + j));
            end
        end
    endtask

    task automatic go(int f, int n);
        start     = 1'b1;
        first_blk = 6'(f);
        nblk      = 7'(n);
        st_cyc    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int lim, bit rnd);
        int c;
        c = 0;
        while (n_done == 0 && c < lim) begin
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        m_axis_tready = 1'b1;
        chk("done_seen", 32'(n_done != 0), 32'd1);
    endtask

    task automatic check_frame(string tag);
        int n;
        chk({tag, "_len"}, 32'(q_data.size()), 32'(e_data.size()));
        n = (q_data.size() < e_data.size()) ? q_data.size() : e_data.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_w%0d", tag, i), q_data[i], e_data[i]);
            chk($sformatf("%s_l%0d", tag, i), 32'(q_last[i]),
                32'(i == e_data.size() - 1));
        end
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        start         = 1'b0;
        first_blk     = '0;
        nblk          = '0;
        m_axis_tready = 1'b1;
        clr();
        repeat (3) tick();
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_addr",   32'(mem_addr), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata",  m_axis_tdata, 32'd0);
        chk("rst_tlast",  32'(m_axis_tlast), 32'd0);
        rst = 1'b0;
        tick();

        // full-rate frame of 16 blocks
        clr();
        build(0, 16);
        go(0, 16);
        wait_done(400, 1'b0);
        check_frame("t1");
        chk("t1_first_tvalid", 32'(first_tv - st_cyc), 32'(MEM_LAT + 2));
        chk("t1_done_lat", 32'(done_cyc - last_cyc), 32'd1);
        chk("t1_rate", 32'(last_cyc - first_hs), 32'd175);
        chk("t1_done_cnt", 32'(n_done), 32'd1);
        chk("t1_reads", 32'(n_en), 32'd160);
        tick();

        // same frame under random backpressure
        clr();
        go(0, 16);
        wait_done(2000, 1'b1);
        check_frame("t2");
        chk("t2_stable", 32'(n_stab), 32'd0);
        tick();

        // block index wrap 63 -> 0
        clr();
        build(62, 3);
        go(62, 3);
        wait_done(200, 1'b0);
        check_frame("t3");
        chk("t3_naddr", 32'(q_addr.size()), 32'(e_addr.size()));
        n = (q_addr.size() < e_addr.size()) ? q_addr.size() : e_addr.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("t3_addr%0d", i), q_addr[i], e_addr[i]);
        tick();

        // empty frame
        clr();
        go(0, 0);
        wait_done(10, 1'b0);
        chk("t4_done_cyc", 32'(done_cyc - st_cyc), 32'd1);
        chk("t4_busy_cycles", 32'(n_busy), 32'd1);
        chk("t4_no_tvalid", 32'(n_tv), 32'd0);
        tick();

        // long stall right after start
        clr();
        build(7, 2);
        m_axis_tready = 1'b0;
        go(7, 2);
        repeat (100) tick();
        chk("t5_stall_reads", 32'(n_en <= FIFO_DEPTH), 32'd1);
        chk("t5_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        chk("t5_no_words", 32'(q_data.size()), 32'd0);
        m_axis_tready = 1'b1;
        wait_done(200, 1'b0);
        check_frame("t5");
        chk("t5_stable", 32'(n_stab), 32'd0);
        tick();

        // ignored second start, then reset mid-frame
        clr();
        build(0, 16);
        go(0, 16);
        n = 0;
        while (q_data.size() < 10 && n < 100) begin tick(); n++; end
        go(33, 1);
        n = 0;
        while (q_data.size() < 40 && n < 100) begin tick(); n++; end
        chk("t6_reached40", 32'(q_data.size() >= 40), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        n = (q_data.size() < e_data.size()) ? q_data.size() : e_data.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("t6_pre%0d", i), q_data[i], e_data[i]);
        repeat (20) tick();
        chk("t6_no_done", 32'(n_done), 32'd0);

        clr();
        build(5, 1);
        go(5, 1);
        wait_done(100, 1'b0);
        check_frame("t6b");
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
